// File: rtl/pt_check.sv
// pt_check: scans decrypted plaintext bytes 1..len and reports whether all are printable ASCII
module pt_check #(
  parameter logic [7:0] LO_CHAR = 8'h20,
  parameter logic [7:0] HI_CHAR = 8'h7E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  input  logic [7:0] msg_length,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic       done,
  output logic       valid,
  output logic [7:0] bad_addr
);
  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_e;
  state_e state_q, state_d;
  logic [7:0] len_q, len_d, addr_q, addr_d, cmp_q, cmp_d, bad_q, bad_d;
  logic valid_q, valid_d;
  logic start, cmp_en, bad, last;
  assign start  = state_q == IDLE && en;
  assign cmp_en = state_q == SCAN && cmp_q != 8'd0;
  assign bad    = cmp_en && (pt_rddata < LO_CHAR || pt_rddata > HI_CHAR);
  assign last   = cmp_en && !bad && cmp_q == len_q;
  // state register
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  // next-state: abort on first bad byte, finish after the last good one
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? (msg_length == 8'd0 ? FIN : SCAN) : IDLE;
      SCAN:    state_d = (bad || last) ? FIN : SCAN;
      default: state_d = IDLE;
    endcase
  end
  // outputs decoded from state
  always_comb begin
    rdy  = state_q == IDLE;
    done = state_q == FIN;
  end
  // datapath: cmp_q names the byte whose read data is on pt_rddata (0 = none yet)
  always_comb begin
    len_d   = start ? msg_length : len_q;
    cmp_d   = start ? 8'd0 : state_q == SCAN ? cmp_q + 8'd1 : cmp_q;
    addr_d  = start ? 8'd1 :
              (state_q == SCAN && addr_q != len_q && !bad) ? addr_q + 8'd1 : addr_q;
    valid_d = start ? msg_length == 8'd0 : last ? 1'b1 : valid_q;
    bad_d   = start ? 8'd0 : bad ? cmp_q : bad_q;
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= 8'd0;
      cmp_q   <= 8'd0;
      addr_q  <= 8'd0;
      valid_q <= 1'b0;
      bad_q   <= 8'd0;
    end else begin
      len_q   <= len_d;
      cmp_q   <= cmp_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      bad_q   <= bad_d;
    end
  end
  assign pt_addr  = addr_q;
  assign valid    = valid_q;
  assign bad_addr = bad_q;
endmodule

// File: tb/tb_pt_check.sv
// tb_pt_check: directed tests of pt_check against a synchronous plaintext RAM model
module tb_pt_check;
  logic clk = 1'b0, rst, en, rdy, done, valid;
  logic [7:0] msg_length, pt_addr, pt_rddata, bad_addr;
  logic [7:0] mem [256];
  int total = 0, passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) pt_rddata <= mem[pt_addr];

  pt_check dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .msg_length(msg_length),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata), .done(done), .valid(valid), .bad_addr(bad_addr)
  );

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic fill(input int n);
    mem[0] = 8'(n);
    for (int i = 1; i < 256; i++) mem[i] = 8'h20 + 8'(i % 95);
  endtask

  // accepts a scan, optionally pokes en/msg_length at cycle 'poke'; cyc = edges after acceptance until done (-1 on timeout)
  task automatic run_scan(input logic [7:0] len, input int poke, input logic [7:0] alt,
                          output int cyc, output int maxa);
    en = 1'b1; msg_length = len;
    step();
    en = 1'b0; cyc = 0; maxa = int'(pt_addr);
    while (!done && cyc < 400) begin
      step(); cyc++;
      if (cyc == poke) begin en = 1'b1; msg_length = alt; end else en = 1'b0;
      if (int'(pt_addr) > maxa) maxa = int'(pt_addr);
    end
    en = 1'b0;
    if (!done) cyc = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; msg_length = 8'd0;
    step(2);
    rst = 1'b0;
    total++; if (rdy !== 1'b1) $display("FAIL reset_rdy got %b exp 1", rdy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid); else passed++;
    total++; if (bad_addr !== 8'd0) $display("FAIL reset_bad_addr got %h exp 00", bad_addr); else passed++;
    total++; if (pt_addr !== 8'd0) $display("FAIL reset_pt_addr got %h exp 00", pt_addr); else passed++;
  endtask

  task automatic test_all_good;
    int cyc, maxa;
    fill(8'h35);
    run_scan(8'h35, 0, 8'h00, cyc, maxa);
    total++; if (cyc != 54) $display("FAIL good_latency got %0d exp 54", cyc); else passed++;
    total++; if (valid !== 1'b1) $display("FAIL good_valid got %b exp 1", valid); else passed++;
    total++; if (bad_addr !== 8'd0) $display("FAIL good_bad_addr got %h exp 00", bad_addr); else passed++;
    total++; if (maxa != 8'h35) $display("FAIL good_max_addr got %h exp 35", maxa); else passed++;
    step();
    total++; if (rdy !== 1'b1 || done !== 1'b0) $display("FAIL good_return got rdy=%b done=%b exp 1 0", rdy, done); else passed++;
    total++; if (pt_addr !== 8'h35) $display("FAIL good_addr_hold got %h exp 35", pt_addr); else passed++;
  endtask

  task automatic test_bad_byte;
    int cyc, maxa;
    fill(8'h35); mem[5] = 8'h0A;
    run_scan(8'h35, 0, 8'h00, cyc, maxa);
    total++; if (cyc != 6) $display("FAIL bad_latency got %0d exp 6", cyc); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL bad_valid got %b exp 0", valid); else passed++;
    total++; if (bad_addr !== 8'd5) $display("FAIL bad_bad_addr got %h exp 05", bad_addr); else passed++;
    total++; if (maxa != 6) $display("FAIL bad_max_addr got %0d exp 6", maxa); else passed++;
    step();
  endtask

  task automatic test_boundary;
    int cyc, maxa;
    fill(4); mem[1] = 8'h20; mem[2] = 8'h7E; mem[3] = 8'h1F; mem[4] = 8'h7F;
    run_scan(8'd4, 0, 8'h00, cyc, maxa);
    total++; if (valid !== 1'b0 || bad_addr !== 8'd3) $display("FAIL bnd_low got valid=%b bad=%h exp 0 03", valid, bad_addr); else passed++;
    total++; if (cyc != 4) $display("FAIL bnd_low_latency got %0d exp 4", cyc); else passed++;
    step();
    mem[3] = 8'h41; mem[4] = 8'h7E;
    run_scan(8'd4, 0, 8'h00, cyc, maxa);
    total++; if (valid !== 1'b1 || bad_addr !== 8'd0) $display("FAIL bnd_ok got valid=%b bad=%h exp 1 00", valid, bad_addr); else passed++;
    total++; if (cyc != 5) $display("FAIL bnd_ok_latency got %0d exp 5", cyc); else passed++;
    step();
    mem[4] = 8'h7F;
    run_scan(8'd4, 0, 8'h00, cyc, maxa);
    total++; if (valid !== 1'b0 || bad_addr !== 8'd4) $display("FAIL bnd_high got valid=%b bad=%h exp 0 04", valid, bad_addr); else passed++;
    step();
  endtask

  task automatic test_len_edges;
    int cyc, maxa;
    run_scan(8'd0, 0, 8'h00, cyc, maxa);
    total++; if (cyc != 0) $display("FAIL len0_latency got %0d exp 0 edges after acceptance", cyc); else passed++;
    total++; if (valid !== 1'b1) $display("FAIL len0_valid got %b exp 1", valid); else passed++;
    step();
    total++; if (pt_addr !== 8'd1 || rdy !== 1'b1) $display("FAIL len0_addr got %h rdy=%b exp 01 1", pt_addr, rdy); else passed++;
    fill(255);
    run_scan(8'd255, 0, 8'h00, cyc, maxa);
    total++; if (cyc != 256) $display("FAIL len255_latency got %0d exp 256", cyc); else passed++;
    total++; if (valid !== 1'b1 || pt_addr !== 8'd255) $display("FAIL len255_result got valid=%b addr=%h exp 1 ff", valid, pt_addr); else passed++;
    step();
    total++; if (pt_addr !== 8'd255) $display("FAIL len255_nowrap got %h exp ff", pt_addr); else passed++;
  endtask

  task automatic test_mid_scan;
    int cyc, maxa, seen;
    fill(10); mem[15] = 8'h0A;
    run_scan(8'd10, 3, 8'd20, cyc, maxa);
    total++; if (cyc != 11) $display("FAIL midscan_latency got %0d exp 11", cyc); else passed++;
    total++; if (valid !== 1'b1 || maxa != 10) $display("FAIL midscan_result got valid=%b max=%0d exp 1 10", valid, maxa); else passed++;
    step();
    en = 1'b1; msg_length = 8'd20;
    step();
    en = 1'b0;
    step(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (rdy !== 1'b1 || done !== 1'b0) $display("FAIL rst_mid got rdy=%b done=%b exp 1 0", rdy, done); else passed++;
    total++; if (valid !== 1'b0 || pt_addr !== 8'd0 || bad_addr !== 8'd0) $display("FAIL rst_mid_regs got valid=%b addr=%h bad=%h exp 0 00 00", valid, pt_addr, bad_addr); else passed++;
    seen = 0;
    repeat (30) begin step(); if (done) seen++; end
    total++; if (seen != 0) $display("FAIL rst_no_done got %0d pulses exp 0", seen); else passed++;
  endtask

  task automatic test_back_to_back;
    int cyc;
    fill(4); mem[2] = 8'h7F;
    en = 1'b1; msg_length = 8'd4;
    cyc = 0;
    step();
    while (!done && cyc < 50) begin step(); cyc++; end
    total++; if (valid !== 1'b0 || bad_addr !== 8'd2) $display("FAIL b2b_first got valid=%b bad=%h exp 0 02", valid, bad_addr); else passed++;
    mem[2] = 8'h41;
    step();
    total++; if (rdy !== 1'b1) $display("FAIL b2b_idle got rdy=%b exp 1", rdy); else passed++;
    step();
    en = 1'b0;
    total++; if (rdy !== 1'b0 || valid !== 1'b0 || bad_addr !== 8'd0 || pt_addr !== 8'd1) $display("FAIL b2b_accept got rdy=%b valid=%b bad=%h addr=%h exp 0 0 00 01", rdy, valid, bad_addr, pt_addr); else passed++;
    cyc = 0;
    while (!done && cyc < 50) begin step(); cyc++; end
    total++; if (cyc != 5) $display("FAIL b2b_latency got %0d exp 5", cyc); else passed++;
    total++; if (valid !== 1'b1 || bad_addr !== 8'd0) $display("FAIL b2b_second got valid=%b bad=%h exp 1 00", valid, bad_addr); else passed++;
    step();
  endtask

  initial begin
    fill(0);
    test_reset;
    test_all_good;
    test_bad_byte;
    test_boundary;
    test_len_edges;
    test_mid_scan;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
